// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC owner and single-outstanding fetch sequencer for the SRAM-like instruction bus.
// Define IF_ADEL_CHECK_EN to turn misaligned fetch addresses into AdEL exceptions instead of bus requests.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_excepttype
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
  localparam logic [31:0] ADEL_EXC = 32'h0001_0000;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d, valid_q, valid_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, exc_q, exc_d;
  logic        redir, adel;
  logic [31:0] tgt;
  assign redir = flush | br_taken;
  assign tgt = flush ? new_pc : br_target;
`ifdef IF_ADEL_CHECK_EN
  assign adel = |fetch_pc_q[1:0];
`else
  assign adel = 1'b0;
`endif
  assign inst_sram_req = (state_q == REQ) && !adel;
  assign inst_sram_addr = fetch_pc_q;
  assign if_valid = valid_q;
  assign if_pc = pc_q;
  assign if_inst = inst_q;
  assign if_excepttype = exc_q;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d = req_pc_q;
    cancel_d = cancel_q;
    valid_d = valid_q;
    pc_d = pc_q;
    inst_d = inst_q;
    exc_d = exc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (adel) begin
          if (!redir) begin
            valid_d = 1'b1;
            pc_d = fetch_pc_q;
            inst_d = '0;
            exc_d = ADEL_EXC;
            state_d = OUT;
          end
        end else if (inst_sram_addr_ok) begin
          // an accepted request must still be drained even if redirected this cycle
          req_pc_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          cancel_d = redir;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (inst_sram_data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q || redir) begin
            state_d = REQ;
          end else begin
            valid_d = 1'b1;
            pc_d = req_pc_q;
            inst_d = inst_sram_rdata;
            exc_d = '0;
            state_d = OUT;
          end
        end else if (redir) begin
          cancel_d = 1'b1;
        end
      end
      OUT: begin
        if (redir || !stall_if) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redir) begin
      fetch_pc_d = tgt;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      cancel_q <= 1'b0;
      valid_q <= 1'b0;
      pc_q <= '0;
      inst_q <= '0;
      exc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      cancel_q <= cancel_d;
      valid_q <= valid_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      exc_q <= exc_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: random and directed stimulus against a transaction-level fetch reference model.
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, stall_if, flush, br_taken, addr_ok, data_ok, req, if_valid;
  logic [31:0] new_pc, br_target, rdata, addr, if_pc, if_inst, if_exc;
  always #5 clk = ~clk;
  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_target(br_target), .inst_sram_req(req), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_excepttype(if_exc)
  );
  int n_chk = 0, n_err = 0;
  int p_addr = 100, dly_min = 0, dly_max = 0, s_cnt = 0;
  bit stray = 0, s_pend = 0;
  logic [31:0] s_addr, hp;
  logic [31:0] iss[$];
  int n;
  bit m_idle, m_pend, m_drop, m_v;
  logic [31:0] m_next, m_paddr, m_pc, m_inst, m_exc;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c1d_0000;
  endfunction
  function automatic logic [31:0] nth(input int i);
    return i < iss.size() ? iss[i] : 32'hxxxxxxxx;
  endfunction
  function automatic bit m_adel();
`ifdef IF_ADEL_CHECK_EN
    return m_next[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(7))
      0: return 32'hfffffffc;
      1: return $urandom;
      default: return 32'hbfc00000 + ($urandom_range(255) << 2);
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic f, input logic b);
    logic [31:0] a, tgt;
    bit rd;
    rst = r; stall_if = s; flush = f; br_taken = b;
    a = addr;
    addr_ok = r && (req === 1'b1) && !s_pend && ($urandom_range(99) < p_addr);
    data_ok = s_pend && s_cnt == 0;
    rdata = data_ok ? mem(s_addr) : $urandom;
    if (!s_pend && stray && $urandom_range(3) == 0) data_ok = 1'b1;
    @(posedge clk);
    if (!r || data_ok) s_pend = 0;
    else if (s_pend) s_cnt--;
    if (addr_ok) begin
      s_pend = 1; s_addr = a; s_cnt = $urandom_range(dly_max, dly_min);
      iss.push_back(a);
    end
    rd = f | b;
    tgt = f ? new_pc : br_target;
    if (!r) begin
      m_idle = 1; m_pend = 0; m_drop = 0; m_v = 0;
      m_next = 32'hbfc00000; m_pc = 0; m_inst = 0; m_exc = 0;
    end else begin
      if (m_idle) m_idle = 0;
      else if (m_v) begin
        if (rd || !s) m_v = 0;
      end else if (m_pend) begin
        if (data_ok) begin
          m_pend = 0;
          if (!(m_drop || rd)) {m_v, m_pc, m_inst, m_exc} = {1'b1, m_paddr, rdata, 32'h0};
          m_drop = 0;
        end else if (rd) m_drop = 1;
      end else if (m_adel()) begin
        if (!rd) {m_v, m_pc, m_inst, m_exc} = {1'b1, m_next, 32'h0, 32'h0001_0000};
      end else if (addr_ok) begin
        m_pend = 1; m_paddr = m_next; m_next = m_next + 32'd4; m_drop = rd;
      end
      if (rd) begin
        m_next = tgt; m_v = 0;
      end
    end
    #1;
    chk("req", req, !m_idle && !m_v && !m_pend && !m_adel());
    chk("addr", addr, m_next);
    chk("valid", if_valid, m_v);
    chk("pc", if_pc, m_pc);
    chk("inst", if_inst, m_inst);
    chk("exc", if_exc, m_exc);
    if (if_valid && if_exc == 0) chk("mem", if_inst, mem(if_pc));
  endtask
  initial begin
    new_pc = 0; br_target = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    iss.delete();
    repeat (12) step(1, 0, 0, 0);
    chk("seq0", nth(0), 32'hbfc00000);
    chk("seq1", nth(1), 32'hbfc00004);
    chk("seq2", nth(2), 32'hbfc00008);
    for (int i = 0; i < 20 && !if_valid; i++) step(1, 1, 0, 0);
    chk("stall_reach", if_valid, 1);
    hp = if_pc; n = iss.size();
    repeat (5) step(1, 1, 0, 0);
    chk("stall_hold", if_pc, hp);
    for (int i = 0; i < 10 && iss.size() == n; i++) step(1, 0, 0, 0);
    chk("stall_next", nth(n), hp + 32'd4);
    dly_min = 2; dly_max = 2;
    for (int i = 0; i < 10 && !s_pend; i++) step(1, 0, 0, 0);
    chk("br_wait", s_pend, 1);
    br_target = 32'hbfc00100; n = iss.size();
    step(1, 0, 0, 1);
    for (int i = 0; i < 20 && iss.size() == n; i++) step(1, 0, 0, 0);
    chk("br_next", nth(n), 32'hbfc00100);
    dly_min = 0; dly_max = 0;
    for (int i = 0; i < 20 && !if_valid; i++) step(1, 1, 0, 0);
    chk("fl_reach", if_valid, 1);
    new_pc = 32'hbfc00380; br_target = 32'hbfc00500; n = iss.size();
    step(1, 1, 1, 1);
    chk("fl_valid", if_valid, 0);
    for (int i = 0; i < 10 && iss.size() == n; i++) step(1, 0, 0, 0);
    chk("fl_next", nth(n), 32'hbfc00380);
    for (int i = 0; i < 10 && !s_pend; i++) step(1, 0, 0, 0);
    chk("rst_wait", s_pend, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_valid", if_valid, 0);
    n = iss.size();
    for (int i = 0; i < 10 && iss.size() == n; i++) step(1, 0, 0, 0);
    chk("rst_next", nth(n), 32'hbfc00000);
    for (int i = 0; i < 10 && !s_pend; i++) step(1, 0, 0, 0);
    br_target = 32'hbfc00102; n = iss.size();
    step(1, 0, 0, 1);
`ifdef IF_ADEL_CHECK_EN
    for (int i = 0; i < 10 && !if_valid; i++) step(1, 1, 0, 0);
    chk("adel_pc", if_pc, 32'hbfc00102);
    chk("adel_exc", if_exc, 32'h0001_0000);
    chk("adel_noreq", iss.size(), n);
`else
    for (int i = 0; i < 10 && iss.size() == n; i++) step(1, 0, 0, 0);
    chk("unal_next", nth(n), 32'hbfc00102);
`endif
    p_addr = 60; dly_max = 3; stray = 1;
    repeat (4000) begin
      new_pc = rand_tgt();
      br_target = rand_tgt();
      step($urandom_range(99) != 0, $urandom_range(99) < 40, $urandom_range(99) < 3, $urandom_range(99) < 6);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller that owns the program counter and sequences requests on the SRAM-like instruction bus. Sits between the stall/flush control logic and the IF/ID pipeline register. Issues one fetch at a time, buffers the returned instruction until decode accepts it, and discards in-flight fetches on flush or taken branch.

## Interface
- RESET_PC, 32'hbfc00000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- stall_if  in  1  decode cannot accept the output instruction this cycle
- flush  in  1  exception/eret redirect; highest priority
- new_pc  in  32  redirect target when flush=1
- br_taken  in  1  taken-branch redirect; ignored when flush=1
- br_target  in  32  redirect target when br_taken=1
- inst_sram_req  out  1  fetch request valid
- inst_sram_addr  out  32  fetch address
- inst_sram_addr_ok  in  1  request accepted this cycle (valid only while req=1)
- inst_sram_data_ok  in  1  read data returned this cycle
- inst_sram_rdata  in  32  returned instruction
- if_valid  out  1  if_pc/if_inst/if_excepttype hold a deliverable instruction
- if_pc  out  32  address of delivered instruction
- if_inst  out  32  delivered instruction word
- if_excepttype  out  32  bit 16 = fetch address error (AdEL); all other bits 0

## Operation
- Registers: fetch_pc (next address to request), req_pc (address in flight), cancel (discard next data_ok), output register {if_valid, if_pc, if_inst, if_excepttype}.
- States: IDLE, REQ, WAIT, OUT.
- IDLE: entered on reset; next cycle -> REQ.
- REQ: inst_sram_req=1, inst_sram_addr=fetch_pc. On addr_ok: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4, -> WAIT.
- WAIT: req=0. On data_ok: if cancel, clear cancel, -> REQ; else load output register {1, req_pc, rdata, 0}, -> OUT.
- OUT: if_valid=1. When stall_if=0 the instruction is consumed: if_valid<=0, -> REQ. While stall_if=1 all outputs hold.
- Redirect (flush, else br_taken) in any state: fetch_pc<=target; if_valid<=0 next cycle (undelivered instruction discarded).
  - REQ without addr_ok: address switches to target next cycle; req stays 1 (bus permits address change before acceptance).
  - REQ with addr_ok same cycle: request counts as issued; cancel<=1, -> WAIT, fetch_pc<=target.
  - WAIT without data_ok: cancel<=1, stay WAIT. WAIT with data_ok: data dropped, cancel<=0, -> REQ.
  - OUT: -> REQ.
- Redirect overrides stall_if. Decode asserts br_taken only after accepting the delay slot.
- Only one request outstanding at any time; fetch_pc+4 wraps modulo 2^32.

## Timing
- Reset (rst=0 at edge): state IDLE, fetch_pc=RESET_PC, cancel=0, req=0, addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, if_excepttype=0. Reset mid-transaction abandons it; stale data_ok after reset is ignored in IDLE/REQ.
- First req=1 in 2nd cycle after rst deasserted.
- Latency with addr_ok and data_ok one cycle apart: req cycle N, data_ok N+1, if_valid N+2; next req N+3 if consumed at N+2.
- inst_sram_req and inst_sram_addr are combinational from state/fetch_pc; all other outputs registered.
- data_ok outside WAIT is ignored.

## Configuration
- IF_ADEL_CHECK_EN defined: in REQ, if fetch_pc[1:0]!=0, no bus request (req=0); next cycle output register loads {1, fetch_pc, 0, 32'h0001_0000}, -> OUT; fetch_pc not advanced. Redirect clears it as usual.
- Undefined: addresses issued unchecked; if_excepttype is constant 0.

## Test plan
- Reset release, addr_ok immediate, data_ok next cycle, stall_if=0 -> addresses bfc00000, bfc00004, bfc00008 issued; if_valid pulses with matching if_pc and rdata.
- stall_if=1 for 5 cycles while in OUT -> if_valid/if_pc/if_inst stable, req=0; on release next req addr = if_pc+4.
- br_taken, br_target=bfc00100, in WAIT, data_ok 3 cycles later -> that data never appears on if_inst; next req addr bfc00100.
- flush(new_pc=bfc00380) and br_taken same cycle in OUT -> if_valid=0 next cycle, next req addr bfc00380.
- rst=0 asserted during WAIT, data_ok during reset -> outputs at reset values; first req after release addr bfc00000.
- With IF_ADEL_CHECK_EN, br_target=bfc00102 -> no req; if_valid=1, if_pc=bfc00102, if_excepttype=00010000; without macro req issued at bfc00102.
